// File: rtl/lamp_ctrl_pkg.sv
// Shared types and helpers for the lamp command arbiter: FSM states,
// requester indices and the modulo-3 index arithmetic used by round-robin.
package lamp_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_BTN   = 2'd0;
    localparam logic [1:0] REQ_KEY   = 2'd1;
    localparam logic [1:0] REQ_SCHED = 2'd2;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == REQ_SCHED) ? REQ_BTN : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        case (oh)
            3'b010:  return REQ_KEY;
            3'b100:  return REQ_SCHED;
            default: return REQ_BTN;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker: the first asserted request
// at or after the pointer (wrapping) wins, reported as a one-hot grant.
module rr_arbiter3
    import lamp_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        gnt   = '0;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/lamp_cmd_arbiter.sv
// Arbitrates lamp on/off commands from three requesters and holds the relay
// busy while it settles. Define LAMP_AUTO_OFF_EN to add the idle auto-off timer.
module lamp_cmd_arbiter
    import lamp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int AUTO_OFF_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_on,
    output logic [NUM_REQ-1:0] gnt,
    output logic               lamp_state,
    output logic               turn_lamp_on,
    output logic               turn_lamp_off,
    output logic               busy,
    output logic               waiting
`ifdef LAMP_AUTO_OFF_EN
    ,
    output logic               auto_off
`endif
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 ||
        AUTO_OFF_CYCLES < 2 || AUTO_OFF_CYCLES > 65535) begin : g_bad_param
        $error("lamp_cmd_arbiter: SETTLE_CYCLES or AUTO_OFF_CYCLES out of range");
    end

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [1:0]         ptr;
    logic [15:0]        settle_cnt;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [1:0]         win_idx;
    logic               win_on;

`ifdef LAMP_AUTO_OFF_EN
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_OFF_CYCLES - 1);
    logic [15:0] idle_cnt;
`endif

    rr_arbiter3 u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    assign win_idx = onehot_idx(rr_gnt);
    assign win_on  = |(rr_gnt & req_on);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= REQ_BTN;
            settle_cnt    <= '0;
            gnt           <= '0;
            lamp_state    <= 1'b0;
            turn_lamp_on  <= 1'b0;
            turn_lamp_off <= 1'b0;
            busy          <= 1'b0;
            waiting       <= 1'b1;
`ifdef LAMP_AUTO_OFF_EN
            idle_cnt      <= '0;
            auto_off      <= 1'b0;
`endif
        end else begin
            gnt           <= '0;
            turn_lamp_on  <= 1'b0;
            turn_lamp_off <= 1'b0;
`ifdef LAMP_AUTO_OFF_EN
            auto_off      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        gnt <= rr_gnt;
                        ptr <= next_idx(win_idx);
`ifdef LAMP_AUTO_OFF_EN
                        idle_cnt <= '0;
`endif
                        // A command matching the current state is acknowledged but does not touch the relay.
                        if (win_on != lamp_state) begin
                            lamp_state    <= win_on;
                            turn_lamp_on  <= win_on;
                            turn_lamp_off <= !win_on;
                            state         <= SETTLE;
                            busy          <= 1'b1;
                            waiting       <= 1'b0;
                            settle_cnt    <= SETTLE_LOAD;
                        end
                    end
`ifdef LAMP_AUTO_OFF_EN
                    else if (lamp_state && idle_cnt == AUTO_LAST) begin
                        lamp_state    <= 1'b0;
                        turn_lamp_off <= 1'b1;
                        auto_off      <= 1'b1;
                        idle_cnt      <= '0;
                        state         <= SETTLE;
                        busy          <= 1'b1;
                        waiting       <= 1'b0;
                        settle_cnt    <= SETTLE_LOAD;
                    end else if (lamp_state) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end else begin
                        idle_cnt <= '0;
                    end
`endif
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        waiting <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    waiting <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_cmd_arbiter.sv
// Directed bench for lamp_cmd_arbiter: a vector table for grant/settle
// sequencing plus hand-written reset-abort and auto-off sequences.
module tb_lamp_cmd_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] req_on = '0;
    logic [2:0] gnt;
    logic       lamp_state, turn_lamp_on, turn_lamp_off, busy, waiting;
`ifdef LAMP_AUTO_OFF_EN
    logic       auto_off;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lamp_cmd_arbiter #(
        .SETTLE_CYCLES   (4),
        .AUTO_OFF_CYCLES (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_on        (req_on),
        .gnt           (gnt),
        .lamp_state    (lamp_state),
        .turn_lamp_on  (turn_lamp_on),
        .turn_lamp_off (turn_lamp_off),
        .busy          (busy),
        .waiting       (waiting)
`ifdef LAMP_AUTO_OFF_EN
        ,
        .auto_off      (auto_off)
`endif
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] req_on;
        logic [2:0] gnt;
        logic       lamp;
        logic       on;
        logic       off;
        logic       busy;
        logic       wait_;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic l,
                           input logic on, input logic off, input logic b, input logic w);
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".lamp_state"}, {2'b0, lamp_state}, {2'b0, l});
        chk({tag, ".turn_lamp_on"}, {2'b0, turn_lamp_on}, {2'b0, on});
        chk({tag, ".turn_lamp_off"}, {2'b0, turn_lamp_off}, {2'b0, off});
        chk({tag, ".busy"}, {2'b0, busy}, {2'b0, b});
        chk({tag, ".waiting"}, {2'b0, waiting}, {2'b0, w});
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] ro, input logic [2:0] g,
                                input logic l, input logic on, input logic off,
                                input logic b, input logic w);
        vec_t v;
        v.req = r; v.req_on = ro; v.gnt = g; v.lamp = l;
        v.on = on; v.off = off; v.busy = b; v.wait_ = w;
        return v;
    endfunction

    initial begin
        // turn on, settle 4 cycles
        vecs[0]  = mk(3'b001, 3'b001, 3'b001, 1, 1, 0, 1, 0);
        vecs[1]  = mk(3'b000, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[2]  = mk(3'b000, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[3]  = mk(3'b000, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[4]  = mk(3'b000, 3'b000, 3'b000, 1, 0, 0, 0, 1);
        // no-op grant moves pointer back to 0
        vecs[5]  = mk(3'b100, 3'b100, 3'b100, 1, 0, 0, 0, 1);
        // all three request off: 001 switches, 010 and 100 are no-ops
        vecs[6]  = mk(3'b111, 3'b000, 3'b001, 0, 0, 1, 1, 0);
        vecs[7]  = mk(3'b110, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[8]  = mk(3'b110, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[9]  = mk(3'b110, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[10] = mk(3'b110, 3'b000, 3'b000, 0, 0, 0, 0, 1);
        vecs[11] = mk(3'b110, 3'b000, 3'b010, 0, 0, 0, 0, 1);
        vecs[12] = mk(3'b100, 3'b000, 3'b100, 0, 0, 0, 0, 1);
        vecs[13] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 1);
        // request arriving during SETTLE waits for IDLE
        vecs[14] = mk(3'b010, 3'b010, 3'b010, 1, 1, 0, 1, 0);
        vecs[15] = mk(3'b000, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[16] = mk(3'b010, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[17] = mk(3'b010, 3'b000, 3'b000, 1, 0, 0, 1, 0);
        vecs[18] = mk(3'b010, 3'b000, 3'b000, 1, 0, 0, 0, 1);
        vecs[19] = mk(3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0);
        vecs[20] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[21] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[22] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 0);
        vecs[23] = mk(3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 1);

        // reset state
        #12;
        chk_all("reset", 3'b000, 0, 0, 0, 0, 1);
`ifdef LAMP_AUTO_OFF_EN
        chk("reset.auto_off", {2'b0, auto_off}, 3'b000);
`endif
        reset = 1'b1;
        tick();
        chk_all("post_reset", 3'b000, 0, 0, 0, 0, 1);

        for (int i = 0; i < 24; i++) begin
            req    = vecs[i].req;
            req_on = vecs[i].req_on;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].lamp, vecs[i].on,
                    vecs[i].off, vecs[i].busy, vecs[i].wait_);
        end

        // reset in SETTLE cycle 2 aborts without a turn-off pulse
        req = 3'b001; req_on = 3'b001;
        tick();
        chk_all("rst_seq.on", 3'b001, 1, 1, 0, 1, 0);
        req = 3'b000; req_on = 3'b000;
        tick();
        #2 reset = 1'b0;
        #1;
        chk_all("rst_seq.abort", 3'b000, 0, 0, 0, 0, 1);
        tick();
        chk_all("rst_seq.held", 3'b000, 0, 0, 0, 0, 1);
        reset = 1'b1;
        tick();
        chk_all("rst_seq.release", 3'b000, 0, 0, 0, 0, 1);
        req = 3'b111; req_on = 3'b000;
        tick();
        chk_all("rst_seq.ptr0", 3'b001, 0, 0, 0, 0, 1);
        req = 3'b100; req_on = 3'b100;
        tick();
        chk_all("rst_seq.sched", 3'b100, 1, 1, 0, 1, 0);
        req = 3'b000; req_on = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        chk_all("rst_seq.idle", 3'b000, 1, 0, 0, 0, 1);

`ifdef LAMP_AUTO_OFF_EN
        // lamp on and idle: auto-off on the 10th idle edge
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("auto.wait%0d", i), {2'b0, auto_off}, 3'b000);
        end
        tick();
        chk("auto.fire", {2'b0, auto_off}, 3'b001);
        chk_all("auto.fire", 3'b000, 0, 0, 1, 1, 0);
        tick();
        chk("auto.pulse_end", {1'b0, auto_off, turn_lamp_off}, 3'b000);
        for (int i = 0; i < 3; i++) tick();
        chk_all("auto.idle", 3'b000, 0, 0, 0, 0, 1);
        req = 3'b001; req_on = 3'b001;
        tick();
        chk_all("auto.on2", 3'b001, 1, 1, 0, 1, 0);
        req = 3'b000; req_on = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 9; i++) tick();
        // external request at the terminal count wins
        req = 3'b010; req_on = 3'b010;
        tick();
        chk("term.auto_off", {2'b0, auto_off}, 3'b000);
        chk_all("term", 3'b010, 1, 0, 0, 0, 1);
        req = 3'b000; req_on = 3'b000;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("restart.wait%0d", i), {2'b0, auto_off}, 3'b000);
        end
        tick();
        chk("restart.fire", {2'b0, auto_off}, 3'b001);
        chk_all("restart.fire", 3'b000, 0, 0, 1, 1, 0);
`else
        // without the timer the lamp stays on indefinitely
        for (int i = 0; i < 30; i++) tick();
        chk_all("no_auto", 3'b000, 1, 0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_cmd_arbiter.md
LAMP_CMD_ARBITER -- requirements
Module: lamp_cmd_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles the lamp relay is held busy after a switch; legal range 1..65535.
REQ-002 Parameter AUTO_OFF_CYCLES, default 1000: idle-on cycles before automatic switch-off; legal range 2..65535.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  3  command request per requester; bit 0 wall buttons, bit 1 keypad, bit 2 scheduler.
REQ-006 Port req_on  input  3  per-requester command value; 1 = lamp on, 0 = lamp off.
REQ-007 Port gnt  output  3  one-hot, one-cycle pulse marking the accepted requester.
REQ-008 Port lamp_state  output  1  current lamp state; 1 = on.
REQ-009 Port turn_lamp_on  output  1  one-cycle pulse when the lamp switches off to on.
REQ-010 Port turn_lamp_off  output  1  one-cycle pulse when the lamp switches on to off.
REQ-011 Port busy  output  1  high while in SETTLE.
REQ-012 Port waiting  output  1  high while in IDLE.
REQ-013 Port auto_off  output  1  one-cycle pulse on a timer-initiated switch-off; present only with the macro in REQ-030.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SETTLE; all outputs registered.
REQ-015 In IDLE with req != 0 at edge N, the block SHALL at N+1 assert gnt for exactly one winner, chosen round-robin starting at the pointer.
REQ-016 The round-robin pointer SHALL reset to 0 and, after a grant to index i, SHALL become (i+1) mod 3.
REQ-017 req_on of the winner SHALL be sampled at edge N; if it differs from lamp_state, then at N+1 lamp_state SHALL take it, the matching turn pulse SHALL fire, and the FSM SHALL enter SETTLE.
REQ-018 If the sampled req_on equals lamp_state, the block SHALL still pulse gnt at N+1, SHALL emit no turn pulse, and SHALL remain in IDLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles (busy high N+1..N+SETTLE_CYCLES), then the FSM SHALL return to IDLE.
REQ-020 In SETTLE, requests SHALL be ignored and gnt SHALL stay 0; requesters hold req until granted.
REQ-021 A requester's req SHALL be deasserted by it the cycle after its gnt; the block SHALL NOT queue commands internally.
REQ-022 gnt, turn_lamp_on and turn_lamp_off SHALL never be high for more than one consecutive cycle per grant.

Reset
REQ-023 While reset is low: FSM = IDLE, lamp_state = 0, gnt = 0, turn pulses = 0, busy = 0, waiting = 1, auto_off = 0, pointer = 0, all counters = 0.
REQ-024 Reset asserted mid-SETTLE SHALL abort immediately to the reset values without a turn_lamp_off pulse.
REQ-025 After reset release, the first grant SHALL be possible on the second rising edge.

Configuration
REQ-026 With the macro defined, an idle counter SHALL count IDLE cycles while lamp_state = 1 and req = 0.
REQ-027 Any grant or lamp_state = 0 SHALL clear the idle counter.
REQ-028 At count AUTO_OFF_CYCLES-1, the next edge SHALL set lamp_state = 0, pulse turn_lamp_off and auto_off, enter SETTLE, and assert no gnt.
REQ-029 If req != 0 at the terminal count, the external request SHALL win and the counter SHALL clear.
REQ-030 Macro LAMP_AUTO_OFF_EN: when undefined, the counter and auto_off port SHALL be absent and the lamp SHALL stay on indefinitely.

Structure
REQ-031 Package lamp_ctrl_pkg SHALL hold the state enum (IDLE, SETTLE), NUM_REQ = 3, and the indices REQ_BTN = 0, REQ_KEY = 1, REQ_SCHED = 2.
REQ-032 Round-robin selection SHALL live in sub-module rr_arbiter3 (req, pointer in; one-hot grant out; combinational).

Verification
REQ-033 Reset, then req = 3'b001 and req_on = 3'b001 one cycle: gnt = 001 next cycle, lamp_state = 1, turn_lamp_on pulse, busy for 4 cycles, then waiting = 1.
REQ-034 With lamp on, hold req = 3'b111 and req_on = 000 until all are granted: grants in order 001, 010, 100; only the first causes turn_lamp_off; the second and third are no-op grants.
REQ-035 Request during SETTLE (req = 010 in cycle 2 of SETTLE): no gnt until IDLE; then gnt = 010 at the first IDLE edge + 1.
REQ-036 With LAMP_AUTO_OFF_EN and AUTO_OFF_CYCLES = 10: turn on, then apply no requests: auto_off and turn_lamp_off pulse exactly 10 IDLE cycles later; lamp_state = 0.
REQ-037 Assert reset low in SETTLE cycle 2 after an on-command: lamp_state = 0 and busy = 0 immediately, no turn pulse; after release, req = 100 grants normally.
REQ-038 With LAMP_AUTO_OFF_EN: req = 010 with req_on = 1 at the terminal idle count: gnt = 010, no auto_off, counter restarts.
